// File: rtl/mips_shift_pkg.sv
// Shared encodings for the sequential MIPS32 shifter: shift opcodes and FSM states.
package mips_shift_pkg;

  localparam logic [1:0] SHOP_SLL  = 2'b00;
  localparam logic [1:0] SHOP_SRL  = 2'b01;
  localparam logic [1:0] SHOP_ROTR = 2'b10;
  localparam logic [1:0] SHOP_SRA  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

endpackage

// File: rtl/shift_step_1.sv
// One-bit shift of the work register selected by op.
// The rotate arm exists only when SEQ_SHIFT_ROTATE_EN is defined; otherwise op=10 acts as SRL.
module shift_step_1
  import mips_shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_comb begin
    case (op)
      SHOP_SLL:  dout = {din[WIDTH-2:0], 1'b0};
      SHOP_SRA:  dout = {din[WIDTH-1], din[WIDTH-1:1]};
`ifdef SEQ_SHIFT_ROTATE_EN
      SHOP_ROTR: dout = {din[0], din[WIDTH-1:1]};
`endif
      default:   dout = {1'b0, din[WIDTH-1:1]};
    endcase
  end

endmodule

// File: rtl/seq_shift_unit.sv
// Iterative shifter: one bit position per clock, start/done handshake to the control FSM.
// Optional rotate-right for op=10 is enabled by defining SEQ_SHIFT_ROTATE_EN.
module seq_shift_unit
  import mips_shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  state_e           state_q, state_d;
  logic [SHW-1:0]   count_q, count_d;
  logic [WIDTH-1:0] work_q,  work_d;
  logic [1:0]       op_q,    op_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic [WIDTH-1:0] work_shifted;

  shift_step_1 #(.WIDTH(WIDTH)) u_step (
    .op   (op_q),
    .din  (work_q),
    .dout (work_shifted)
  );

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d = state_q;
    count_d = count_q;
    work_d  = work_q;
    op_d    = op_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = data_in;
          op_d    = op;
          count_d = shamt;
          state_d = (shamt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        work_d  = work_shifted;
        count_d = count_q - 1'b1;
        if (count_q == SHW'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they carry no input-to-output path.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      work_q  <= '0;
      op_q    <= SHOP_SLL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so all flops sample pre-edge values together.
      state_q <= state_d;
      count_q <= count_d;
      work_q  <= work_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = work_q;

endmodule
